// File: rtl/debounce_fsm.sv
// debounce_fsm: tick-driven switch debouncer with registered level/rise/fall.
// Define DEBOUNCE_SYNC_EN to pass sw through a two-flop synchronizer first.
module debounce_fsm #(
    parameter int Ticks = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int CW = $clog2(Ticks + 1);
    localparam logic [CW-1:0] LAST = CW'(Ticks - 1);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sw_i;
    logic          level_n, rise_n, fall_n;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sw};
        end
    end

    assign sw_i = sync_q[1];
`else
    assign sw_i = sw;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            db_level <= level_n;
            db_rise  <= rise_n;
            db_fall  <= fall_n;
        end
    end

    // A revert of sw always beats a same-cycle tick.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            ZERO: begin
                if (sw_i) begin
                    state_n = WAIT1;
                    cnt_n   = '0;
                end
            end
            WAIT1: begin
                if (!sw_i) begin
                    state_n = ZERO;
                end else if (tick) begin
                    if (cnt == LAST) state_n = ONE;
                    else             cnt_n   = cnt + 1'b1;
                end
            end
            ONE: begin
                if (!sw_i) begin
                    state_n = WAIT0;
                    cnt_n   = '0;
                end
            end
            WAIT0: begin
                if (sw_i) begin
                    state_n = ONE;
                end else if (tick) begin
                    if (cnt == LAST) state_n = ZERO;
                    else             cnt_n   = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ZERO;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        level_n = (state_n == ONE) || (state_n == WAIT0);
        rise_n  = (state == WAIT1) && (state_n == ONE);
        fall_n  = (state == WAIT0) && (state_n == ZERO);
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: scoreboard bench for debounce_fsm (Ticks=3, tick every 4 cycles).
// Honors DEBOUNCE_SYNC_EN in its reference model and latency bounds.
module tb_debounce_fsm;

    localparam int TICKS = 3;
    localparam int P     = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LMIN = (TICKS - 1) * P + 1 + SYNC;
    localparam int LMAX = TICKS * P + SYNC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic sw = 1'b0;
    logic db_level, db_rise, db_fall;

    debounce_fsm #(.Ticks(TICKS)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .sw      (sw),
        .db_level(db_level),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int phase    = 0;
    int rises    = 0;
    int falls    = 0;
    logic seen_level = 1'b0;
    logic [2:0] exp_q[$];

    // Reference model: "pending" means the visible sw differs from level.
    logic       m_level = 1'b0;
    logic       m_pend  = 1'b0;
    int         m_cnt   = 0;
    logic       m_rise  = 1'b0;
    logic       m_fall  = 1'b0;
    logic [1:0] m_sync  = 2'b00;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic s, input logic t, input logic r);
        logic s_eff;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!r) begin
            m_level = 1'b0;
            m_pend  = 1'b0;
            m_cnt   = 0;
            m_sync  = 2'b00;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            s_eff  = m_sync[1];
            m_sync = {m_sync[0], s};
`else
            s_eff = s;
`endif
            if (!m_pend) begin
                if (s_eff != m_level) begin
                    m_pend = 1'b1;
                    m_cnt  = 0;
                end
            end else if (s_eff == m_level) begin
                m_pend = 1'b0;
            end else if (t) begin
                m_cnt++;
                if (m_cnt == TICKS) begin
                    m_level = s_eff;
                    m_pend  = 1'b0;
                    m_rise  = s_eff;
                    m_fall  = !s_eff;
                end
            end
        end
    endtask

    task automatic step(input logic s, input logic r);
        logic [2:0] e;
        logic       t;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outs", int'({db_level, db_rise, db_fall}), int'(e));
            check("excl", int'(db_rise & db_fall), 0);
            seen_level = db_level;
            if (db_rise) rises++;
            if (db_fall) falls++;
        end
        t     = (phase == P - 1);
        phase = (phase + 1) % P;
        sw    = s;
        tick  = t;
        rst   = r;
        model(s, t, r);
        exp_q.push_back({m_level, m_rise, m_fall});
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b1);
    endtask

    task automatic press(output int lat);
        lat = -1;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1);
            if (seen_level && lat < 0) lat = i - 1;
        end
    endtask

    task automatic two_ticks(output logic ok);
        int tk;
        logic t_next;
        tk = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            t_next = (phase == P - 1);
            step(1'b1, 1'b1);
            if (t_next && i > 0) tk++;
            if (tk == 2) ok = 1'b1;
        end
    endtask

    initial begin
        int   r0, f0, lat;
        logic ok, s, t_next, found;

        // Reset held with sw high and ticks running.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check("rst_level", int'(seen_level), 0);
        check("rst_rises", rises, 0);

        // Release: rise after three fresh ticks.
        r0 = rises;
        press(lat);
        check("rst_rel_lat", int'(lat >= LMIN && lat <= LMAX), 1);
        check("rst_rel_rise", rises - r0, 1);

        f0 = falls;
        hold(1'b0, 20);
        check("release_fall", falls - f0, 1);
        check("release_level", int'(seen_level), 0);

        // Clean press.
        r0 = rises;
        press(lat);
        check("press_lat", int'(lat >= LMIN && lat <= LMAX), 1);
        check("press_rise", rises - r0, 1);
        check("press_level", int'(seen_level), 1);
        f0 = falls;
        hold(1'b0, 20);
        check("press_fall", falls - f0, 1);

        // Bounce after two ticks.
        r0 = rises;
        two_ticks(ok);
        check("bounce_setup", int'(ok), 1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("bounce_early", rises - r0, 0);
        hold(1'b1, 30);
        check("bounce_rise", rises - r0, 1);
        hold(1'b0, 20);
        check("bounce_level", int'(seen_level), 0);

        // sw drops in the same cycle as the accepting tick.
        r0    = rises;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            t_next = (phase == P - 1);
            s = !(m_pend && m_cnt == TICKS - 1 && t_next && !m_level);
            step(s, 1'b1);
            if (!s) found = 1'b1;
        end
        check("simul_found", int'(found), 1);
        hold(1'b0, 12);
`ifndef DEBOUNCE_SYNC_EN
        check("simul_rise", rises - r0, 0);
`endif
        check("simul_level", int'(seen_level), 0);

        // Reset in the middle of WAIT1.
        two_ticks(ok);
        check("midrst_setup", int'(ok), 1);
        step(1'b1, 1'b0);
        r0 = rises;
        press(lat);
        check("midrst_lat", int'(lat >= LMIN && lat <= LMAX), 1);
        check("midrst_rise", rises - r0, 1);

        hold(1'b0, 20);
        check("end_level", int'(seen_level), 0);
        check("queue_depth", exp_q.size(), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
